// File: rtl/beat_voice_if.sv
// Audio sample stream from the drum voice toward the codec.
// A sample counts as accepted on any cycle where sample_valid and sample_ready are both high.
interface beat_voice_if;
    logic [15:0] sample_out;
    logic        sample_valid;
    logic        sample_ready;

    modport master (
        output sample_out,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample_out,
        input  sample_valid,
        output sample_ready
    );
endinterface

// File: rtl/beat_voice.sv
// Drum voice: turns detected beats into a decaying square-wave hit.
// Output is a continuous 16-bit sample stream, one sample per CLK_DIV clocks.
module beat_voice #(
    parameter int CLK_DIV   = 1042,
    parameter int TONE_HALF = 24,
    parameter int DUR_1     = 2400,
    parameter int DUR_2     = 4800,
    parameter int DUR_3     = 9600,
    parameter int HOLDOFF   = 4800,
    parameter int ENV_STEP  = 256
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               beat_en,
    input  logic [1:0]         beat_intensity,
    beat_voice_if.master       smp,
    output logic               busy,
    output logic [7:0]         beat_count,
    output logic [7:0]         drop_count,
    output logic               overrun
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PLAYING,
        ST_HOLDOFF
    } state_t;

    state_t            state_reg, state_next;
    logic [DIV_W-1:0]  div_reg, div_next;
    logic              beat_prev_reg;
    logic [1:0]        int_reg, int_next;
    logic [15:0]       amp_reg, amp_next;
    logic              phase_reg, phase_next;
    logic [15:0]       tone_reg, tone_next;
    logic [15:0]       env_reg, env_next;
    logic [15:0]       dur_reg, dur_next;
    logic [15:0]       hold_reg, hold_next;
    logic [15:0]       sample_out_reg, sample_out_next;
    logic              sample_valid_reg, sample_valid_next;
    logic [7:0]        beat_count_reg, beat_count_next;
    logic [7:0]        drop_count_reg, drop_count_next;
    logic              overrun_reg, overrun_next;

    logic              tick;
    logic              rise;
    logic              trig;
    logic              accept;
    logic              drop;
    logic [15:0]       tone_sample;
    logic [15:0]       new_sample;
    logic [15:0]       dur_len;

    // Per-intensity starting amplitude and hit length; index 0 is never used for a hit.
    logic [15:0] amp_lut [4];
    logic [15:0] dur_lut [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lut
            assign amp_lut[gi] = (gi == 1) ? 16'h1000 :
                                 (gi == 2) ? 16'h2000 :
                                 (gi == 3) ? 16'h3FFF : 16'h0000;
            assign dur_lut[gi] = (gi == 1) ? 16'(DUR_1) :
                                 (gi == 2) ? 16'(DUR_2) :
                                 (gi == 3) ? 16'(DUR_3) : 16'd0;
        end
    endgenerate

    assign tick = (div_reg == DIV_LAST);
    assign rise = beat_en && !beat_prev_reg;
    assign trig = rise && (beat_intensity != 2'b00);

    // Only a strictly stronger beat may interrupt a hit in progress.
    assign accept = trig && ((state_reg == ST_IDLE) ||
                             ((state_reg == ST_PLAYING) && (beat_intensity > int_reg)));
    assign drop   = trig && !accept;

    assign dur_len     = dur_lut[int_reg];
    assign tone_sample = phase_reg ? amp_reg : (~amp_reg + 16'd1);
    assign new_sample  = (state_reg == ST_PLAYING) ? tone_sample : 16'h0000;

    always_comb begin
        state_next        = state_reg;
        div_next          = tick ? '0 : div_reg + DIV_W'(1);
        int_next          = int_reg;
        amp_next          = amp_reg;
        phase_next        = phase_reg;
        tone_next         = tone_reg;
        env_next          = env_reg;
        dur_next          = dur_reg;
        hold_next         = hold_reg;
        sample_out_next   = sample_out_reg;
        sample_valid_next = sample_valid_reg;
        beat_count_next   = beat_count_reg;
        drop_count_next   = drop_count_reg;
        overrun_next      = overrun_reg;

        unique case (state_reg)
            ST_IDLE: begin
            end
            ST_PLAYING: begin
                if (tick) begin
                    if (tone_reg + 16'd1 == 16'(TONE_HALF)) begin
                        tone_next  = 16'd0;
                        phase_next = !phase_reg;
                    end else begin
                        tone_next = tone_reg + 16'd1;
                    end
                    if (env_reg + 16'd1 == 16'(ENV_STEP)) begin
                        env_next = 16'd0;
                        amp_next = amp_reg - (amp_reg >> 3);
                    end else begin
                        env_next = env_reg + 16'd1;
                    end
                    dur_next = dur_reg + 16'd1;
                    if (dur_reg + 16'd1 == dur_len) begin
                        state_next = ST_HOLDOFF;
                        hold_next  = 16'd0;
                    end
                end
            end
            ST_HOLDOFF: begin
                if (tick) begin
                    hold_next = hold_reg + 16'd1;
                    if (hold_reg + 16'd1 == 16'(HOLDOFF)) begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // An accepted trigger overrides any expiry or counter update from the same cycle.
        if (accept) begin
            state_next      = ST_PLAYING;
            int_next        = beat_intensity;
            amp_next        = amp_lut[beat_intensity];
            phase_next      = 1'b1;
            tone_next       = 16'd0;
            env_next        = 16'd0;
            dur_next        = 16'd0;
            beat_count_next = beat_count_reg + 8'd1;
        end

        if (drop && (drop_count_reg != 8'hFF)) begin
            drop_count_next = drop_count_reg + 8'd1;
        end

        if (tick) begin
            sample_out_next   = new_sample;
            sample_valid_next = 1'b1;
            if (sample_valid_reg && !smp.sample_ready) begin
                overrun_next = 1'b1;
            end
        end else if (sample_valid_reg && smp.sample_ready) begin
            sample_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= ST_IDLE;
            div_reg          <= '0;
            beat_prev_reg    <= 1'b0;
            int_reg          <= 2'b00;
            amp_reg          <= 16'd0;
            phase_reg        <= 1'b0;
            tone_reg         <= 16'd0;
            env_reg          <= 16'd0;
            dur_reg          <= 16'd0;
            hold_reg         <= 16'd0;
            sample_out_reg   <= 16'd0;
            sample_valid_reg <= 1'b0;
            beat_count_reg   <= 8'd0;
            drop_count_reg   <= 8'd0;
            overrun_reg      <= 1'b0;
        end else begin
            state_reg        <= state_next;
            div_reg          <= div_next;
            beat_prev_reg    <= beat_en;
            int_reg          <= int_next;
            amp_reg          <= amp_next;
            phase_reg        <= phase_next;
            tone_reg         <= tone_next;
            env_reg          <= env_next;
            dur_reg          <= dur_next;
            hold_reg         <= hold_next;
            sample_out_reg   <= sample_out_next;
            sample_valid_reg <= sample_valid_next;
            beat_count_reg   <= beat_count_next;
            drop_count_reg   <= drop_count_next;
            overrun_reg      <= overrun_next;
        end
    end

    assign smp.sample_out   = sample_out_reg;
    assign smp.sample_valid = sample_valid_reg;
    assign busy             = (state_reg != ST_IDLE);
    assign beat_count       = beat_count_reg;
    assign drop_count       = drop_count_reg;
    assign overrun          = overrun_reg;

endmodule

// File: tb/tb_beat_voice.sv
// Directed bench for beat_voice using small timing parameters.
// Samples are collected on the falling edge whenever valid and ready are both high.
module tb_beat_voice;

    logic       clk;
    logic       rst;
    logic       beat_en;
    logic [1:0] beat_intensity;
    logic       busy;
    logic [7:0] beat_count;
    logic [7:0] drop_count;
    logic       overrun;

    beat_voice_if smp();

    beat_voice #(
        .CLK_DIV   (4),
        .TONE_HALF (2),
        .DUR_1     (8),
        .DUR_2     (16),
        .DUR_3     (32),
        .HOLDOFF   (4),
        .ENV_STEP  (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .beat_en        (beat_en),
        .beat_intensity (beat_intensity),
        .smp            (smp),
        .busy           (busy),
        .beat_count     (beat_count),
        .drop_count     (drop_count),
        .overrun        (overrun)
    );

    int tests_run;
    int tests_failed;
    logic [15:0] cap_q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (smp.sample_valid && smp.sample_ready) cap_q.push_back(smp.sample_out);
        end
    endtask

    // Runs until busy has been seen high and then low again.
    task automatic capture_hit(input int max_cyc, output bit timed_out);
        bit seen;
        seen = 1'b0;
        timed_out = 1'b1;
        for (int i = 0; i < max_cyc; i++) begin
            step(1);
            if (busy) seen = 1'b1;
            else if (seen) begin
                timed_out = 1'b0;
                return;
            end
        end
    endtask

    task automatic test_reset();
        int nz;
        rst = 1'b1; beat_en = 1'b0; beat_intensity = 2'b00; smp.sample_ready = 1'b1;
        step(3);
        tests_run++;
        if ({smp.sample_out, smp.sample_valid, busy, beat_count, drop_count, overrun} !== 35'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got out=%h valid=%b busy=%b bc=%0d dc=%0d ovr=%b, expected all 0",
                     smp.sample_out, smp.sample_valid, busy, beat_count, drop_count, overrun);
        end
        rst = 1'b0;
        cap_q.delete();
        step(40);
        nz = 0;
        foreach (cap_q[i]) if (cap_q[i] != 16'h0000) nz++;
        tests_run++;
        if (cap_q.size() != 10) begin
            tests_failed++;
            $display("FAIL idle_sample_count: got %0d, expected 10", cap_q.size());
        end
        tests_run++;
        if (nz != 0) begin
            tests_failed++;
            $display("FAIL idle_sample_zero: got %0d nonzero, expected 0", nz);
        end
        tests_run++;
        if ({busy, beat_count, drop_count} !== 17'd0) begin
            tests_failed++;
            $display("FAIL idle_status: got busy=%b bc=%0d dc=%0d, expected 0 0 0", busy, beat_count, drop_count);
        end
        $display("[TB] reset/idle: %0d samples", cap_q.size());
    endtask

    task automatic test_single_hit();
        logic [15:0] exp_s [12] = '{16'h1000, 16'h1000, 16'hF000, 16'hF000,
                                    16'h0E00, 16'h0E00, 16'hF200, 16'hF200,
                                    16'h0000, 16'h0000, 16'h0000, 16'h0000};
        bit to;
        int f;
        logic [15:0] got;
        cap_q.delete();
        beat_intensity = 2'b01; beat_en = 1'b1;
        step(2);
        beat_en = 1'b0;
        capture_hit(200, to);
        tests_run++;
        if (to) begin
            tests_failed++;
            $display("FAIL single_timeout: busy did not fall within 200 cycles");
        end
        f = -1;
        foreach (cap_q[i]) if (f < 0 && cap_q[i] != 16'h0000) f = i;
        tests_run++;
        if (f < 0 || cap_q.size() - f != 12) begin
            tests_failed++;
            $display("FAIL single_length: got tail %0d (first nz %0d), expected 12", (f < 0) ? 0 : cap_q.size() - f, f);
        end
        for (int i = 0; i < 12; i++) begin
            got = (f >= 0 && f + i < cap_q.size()) ? cap_q[f + i] : 16'hxxxx;
            tests_run++;
            if (got !== exp_s[i]) begin
                tests_failed++;
                $display("FAIL single_sample[%0d]: got %h, expected %h", i, got, exp_s[i]);
            end
        end
        tests_run++;
        if (beat_count !== 8'd1) begin
            tests_failed++;
            $display("FAIL single_beat_count: got %0d, expected 1", beat_count);
        end
        $display("[TB] single hit: %0d samples captured", cap_q.size());
    endtask

    task automatic test_retrigger();
        logic [15:0] exp_s [8] = '{16'h3FFF, 16'h3FFF, 16'hC001, 16'hC001,
                                   16'h3800, 16'h3800, 16'hC800, 16'hC800};
        bit to;
        int r;
        int nz;
        logic [15:0] got;
        cap_q.delete();
        beat_intensity = 2'b01; beat_en = 1'b1; step(2); beat_en = 1'b0;
        step(10);
        beat_intensity = 2'b11; beat_en = 1'b1; step(2); beat_en = 1'b0;
        step(20);
        beat_intensity = 2'b10; beat_en = 1'b1; step(2); beat_en = 1'b0;
        capture_hit(400, to);
        tests_run++;
        if (to) begin
            tests_failed++;
            $display("FAIL retrig_timeout: busy did not fall within 400 cycles");
        end
        r = -1;
        foreach (cap_q[i]) if (r < 0 && cap_q[i] == 16'h3FFF) r = i;
        for (int i = 0; i < 8; i++) begin
            got = (r >= 0 && r + i < cap_q.size()) ? cap_q[r + i] : 16'hxxxx;
            tests_run++;
            if (got !== exp_s[i]) begin
                tests_failed++;
                $display("FAIL retrig_sample[%0d]: got %h, expected %h", i, got, exp_s[i]);
            end
        end
        nz = 0;
        if (r >= 0) for (int i = r; i < cap_q.size(); i++) if (cap_q[i] != 16'h0000) nz++;
        tests_run++;
        if (nz != 32) begin
            tests_failed++;
            $display("FAIL retrig_length: got %0d nonzero, expected 32", nz);
        end
        tests_run++;
        if (beat_count !== 8'd3 || drop_count !== 8'd1) begin
            tests_failed++;
            $display("FAIL retrig_counts: got bc=%0d dc=%0d, expected bc=3 dc=1", beat_count, drop_count);
        end
        $display("[TB] retrigger: bc=%0d dc=%0d", beat_count, drop_count);
    endtask

    task automatic test_holdoff();
        bit to;
        int nz;
        int idx;
        int late_nz;
        cap_q.delete();
        beat_intensity = 2'b01; beat_en = 1'b1; step(1); beat_en = 1'b0;
        nz = 0;
        for (int i = 0; i < 200 && nz < 8; i++) begin
            step(1);
            nz = 0;
            foreach (cap_q[k]) if (cap_q[k] != 16'h0000) nz++;
        end
        tests_run++;
        if (nz != 8) begin
            tests_failed++;
            $display("FAIL holdoff_wait: got %0d nonzero, expected 8 within 200 cycles", nz);
        end
        idx = cap_q.size();
        beat_intensity = 2'b11; beat_en = 1'b1; step(2); beat_en = 1'b0;
        capture_hit(100, to);
        step(40);
        late_nz = 0;
        for (int i = idx; i < cap_q.size(); i++) if (cap_q[i] != 16'h0000) late_nz++;
        tests_run++;
        if (to) begin
            tests_failed++;
            $display("FAIL holdoff_timeout: busy did not fall within 100 cycles");
        end
        tests_run++;
        if (late_nz != 0) begin
            tests_failed++;
            $display("FAIL holdoff_audio: got %0d nonzero after holdoff edge, expected 0", late_nz);
        end
        tests_run++;
        if (beat_count !== 8'd4 || drop_count !== 8'd2 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL holdoff_counts: got bc=%0d dc=%0d busy=%b, expected bc=4 dc=2 busy=0",
                     beat_count, drop_count, busy);
        end
        $display("[TB] holdoff: bc=%0d dc=%0d", beat_count, drop_count);
    endtask

    task automatic test_level_hold();
        int nz;
        int f;
        cap_q.delete();
        beat_intensity = 2'b10; beat_en = 1'b1;
        step(100);
        beat_en = 1'b0;
        step(20);
        nz = 0; f = -1;
        foreach (cap_q[i]) if (cap_q[i] != 16'h0000) begin
            nz++;
            if (f < 0) f = i;
        end
        tests_run++;
        if (nz != 16) begin
            tests_failed++;
            $display("FAIL level_length: got %0d nonzero, expected 16", nz);
        end
        tests_run++;
        if (f < 0 || cap_q[f] !== 16'h2000) begin
            tests_failed++;
            $display("FAIL level_amp: got %h, expected 2000", (f < 0) ? 16'h0000 : cap_q[f]);
        end
        tests_run++;
        if (beat_count !== 8'd5 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL level_count: got bc=%0d busy=%b, expected bc=5 busy=0", beat_count, busy);
        end
        cap_q.delete();
        beat_intensity = 2'b00; beat_en = 1'b1; step(2); beat_en = 1'b0;
        step(20);
        nz = 0;
        foreach (cap_q[i]) if (cap_q[i] != 16'h0000) nz++;
        tests_run++;
        if (nz != 0 || busy !== 1'b0 || beat_count !== 8'd5 || drop_count !== 8'd2) begin
            tests_failed++;
            $display("FAIL zero_intensity: got nz=%0d busy=%b bc=%0d dc=%0d, expected 0 0 5 2",
                     nz, busy, beat_count, drop_count);
        end
        $display("[TB] level hold: bc=%0d dc=%0d", beat_count, drop_count);
    endtask

    task automatic test_overrun_reset();
        tests_run++;
        if (overrun !== 1'b0) begin
            tests_failed++;
            $display("FAIL overrun_clear: got %b, expected 0", overrun);
        end
        smp.sample_ready = 1'b0;
        step(9);
        smp.sample_ready = 1'b1;
        tests_run++;
        if (overrun !== 1'b1) begin
            tests_failed++;
            $display("FAIL overrun_set: got %b, expected 1", overrun);
        end
        step(20);
        tests_run++;
        if (overrun !== 1'b1) begin
            tests_failed++;
            $display("FAIL overrun_sticky: got %b, expected 1", overrun);
        end
        beat_intensity = 2'b11; beat_en = 1'b1; step(1); beat_en = 1'b0;
        step(20);
        tests_run++;
        if (busy !== 1'b1 || beat_count !== 8'd6) begin
            tests_failed++;
            $display("FAIL midhit_state: got busy=%b bc=%0d, expected busy=1 bc=6", busy, beat_count);
        end
        rst = 1'b1;
        step(1);
        tests_run++;
        if ({smp.sample_out, smp.sample_valid, busy, beat_count, drop_count, overrun} !== 35'd0) begin
            tests_failed++;
            $display("FAIL midhit_reset: got out=%h valid=%b busy=%b bc=%0d dc=%0d ovr=%b, expected all 0",
                     smp.sample_out, smp.sample_valid, busy, beat_count, drop_count, overrun);
        end
        // beat_en high across reset release must trigger on the first cycle.
        beat_intensity = 2'b01; beat_en = 1'b1;
        step(2);
        rst = 1'b0;
        step(1);
        tests_run++;
        if (busy !== 1'b1 || beat_count !== 8'd1) begin
            tests_failed++;
            $display("FAIL reset_release_trigger: got busy=%b bc=%0d, expected busy=1 bc=1", busy, beat_count);
        end
        beat_en = 1'b0;
        step(4);
        $display("[TB] overrun/reset: ovr=%b bc=%0d", overrun, beat_count);
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        test_reset();
        test_single_hit();
        test_retrigger();
        test_holdoff();
        test_level_hold();
        test_overrun_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
